// File: rtl/calc1_port_requester.sv
// calc1_port_requester: takes one host operation at a time, sends it to a calc1 port
// as a two-cycle command (cmd+op_a, then op_b), waits a bounded time for the response,
// and holds the result for the host until it is consumed.
module calc1_port_requester #(
    parameter int TIMEOUT = 64,   // WAIT cycles before an op is abandoned (>=2)
    parameter int CNT_W   = 16    // width of the completed-op counter
) (
    input  logic             c_clk,
    input  logic             reset,        // asynchronous, active-low
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [0:3]       op_cmd,
    input  logic [0:31]      op_a,
    input  logic [0:31]      op_b,
    output logic [0:3]       req_cmd,
    output logic [0:31]      req_data,
    input  logic [0:1]       out_resp,
    input  logic [0:31]      out_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [0:1]       res_resp,
    output logic [0:31]      res_data,
    output logic             res_timeout,
    output logic             err_spurious,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int                WCNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_A,
        ST_SEND_B,
        ST_WAIT,
        ST_RESULT
    } state_t;

    state_t            state_q, state_d;
    logic [0:31]       b_q, b_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [0:3]        req_cmd_q, req_cmd_d;
    logic [0:31]       req_data_q, req_data_d;
    logic [0:1]        res_resp_q, res_resp_d;
    logic [0:31]       res_data_q, res_data_d;
    logic              res_timeout_q, res_timeout_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  done_q, done_d;

    // Next-state, next bus value and result capture for the whole request sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d       = state_q;
        b_d           = b_q;
        wait_cnt_d    = wait_cnt_q;
        req_cmd_d     = '0;
        req_data_d    = '0;
        res_resp_d    = res_resp_q;
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;
        done_d        = done_q;
        // A response is only legal while waiting; anything else is latched as an error.
        err_d         = err_q | ((out_resp != 2'd0) && (state_q != ST_WAIT));

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    b_d = op_b;
                    if (op_cmd != 4'd0) begin
                        // Bus is registered, so the first beat is loaded on the accept edge.
                        state_d    = ST_SEND_A;
                        req_cmd_d  = op_cmd;
                        req_data_d = op_a;
                    end else begin
                        // No-op completes locally without touching the port.
                        state_d       = ST_RESULT;
                        res_resp_d    = 2'd0;
                        res_data_d    = '0;
                        res_timeout_d = 1'b0;
                    end
                end
            end
            ST_SEND_A: begin
                state_d    = ST_SEND_B;
                req_data_d = b_q;
            end
            ST_SEND_B: begin
                state_d    = ST_WAIT;
                wait_cnt_d = '0;
            end
            ST_WAIT: begin
                if (out_resp != 2'd0) begin
                    // A response on the terminal-count cycle still counts as a normal reply.
                    state_d       = ST_RESULT;
                    res_resp_d    = out_resp;
                    res_data_d    = out_data;
                    res_timeout_d = 1'b0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d       = ST_RESULT;
                    res_resp_d    = 2'd3;
                    res_data_d    = '0;
                    res_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                    done_d  = done_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops the bus and discards any op in flight.
    always_ff @(posedge c_clk or negedge reset) begin
        // NOTE: all registers, including captured data, are reset so no output is ever X.
        if (!reset) begin
            state_q       <= ST_IDLE;
            b_q           <= '0;
            wait_cnt_q    <= '0;
            req_cmd_q     <= '0;
            req_data_q    <= '0;
            res_resp_q    <= '0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
            err_q         <= 1'b0;
            done_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            b_q           <= b_d;
            wait_cnt_q    <= wait_cnt_d;
            req_cmd_q     <= req_cmd_d;
            req_data_q    <= req_data_d;
            res_resp_q    <= res_resp_d;
            res_data_q    <= res_data_d;
            res_timeout_q <= res_timeout_d;
            err_q         <= err_d;
            done_q        <= done_d;
        end
    end

    assign op_ready     = (state_q == ST_IDLE);
    assign res_valid    = (state_q == ST_RESULT);
    assign req_cmd      = req_cmd_q;
    assign req_data     = req_data_q;
    assign res_resp     = res_resp_q;
    assign res_data     = res_data_q;
    assign res_timeout  = res_timeout_q & res_valid;
    assign err_spurious = err_q;
    assign done_cnt     = done_q;

endmodule

// File: tb/tb_calc1_port_requester.sv
// Testbench for calc1_port_requester: transaction-level timeline model of each op
// (accept, two bus beats, bounded wait, held result) checked every cycle.
module tb_calc1_port_requester;

    localparam int TMO = 64;
    localparam int CW  = 4;   // narrow counter so the wrap is reached

    logic          c_clk = 1'b0;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic [0:3]    op_cmd;
    logic [0:31]   op_a;
    logic [0:31]   op_b;
    logic [0:3]    req_cmd;
    logic [0:31]   req_data;
    logic [0:1]    out_resp;
    logic [0:31]   out_data;
    logic          res_valid;
    logic          res_ready;
    logic [0:1]    res_resp;
    logic [0:31]   res_data;
    logic          res_timeout;
    logic          err_spurious;
    logic [CW-1:0] done_cnt;

    calc1_port_requester #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .c_clk(c_clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_cmd(op_cmd), .op_a(op_a), .op_b(op_b), .req_cmd(req_cmd), .req_data(req_data),
        .out_resp(out_resp), .out_data(out_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_resp(res_resp), .res_data(res_data), .res_timeout(res_timeout),
        .err_spurious(err_spurious), .done_cnt(done_cnt)
    );

    always #5 c_clk = ~c_clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // expected outputs for the current cycle
    logic          e_op_ready, e_res_valid, e_to, e_err;
    logic [3:0]    e_req_cmd;
    logic [31:0]   e_req_data, e_rdata;
    logic [1:0]    e_resp;
    logic [CW-1:0] e_done;

    // model state
    bit          m_err  = 1'b0;
    int          m_done = 0;
    logic [1:0]  m_resp = '0;
    logic [31:0] m_data = '0;
    logic        m_to   = 1'b0;

    // observations of the first result cycle of an op
    int          cyc_idx;
    int          obs_off;
    logic [1:0]  obs_resp;
    logic [31:0] obs_data;
    logic        obs_to;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge c_clk) begin
        if (chk_en) begin
            check("op_ready", op_ready, e_op_ready);
            check("res_valid", res_valid, e_res_valid);
            check("req_cmd", req_cmd, e_req_cmd);
            check("req_data", req_data, e_req_data);
            check("res_timeout", res_timeout, e_to);
            check("err_spurious", err_spurious, e_err);
            check("done_cnt", done_cnt, e_done);
            if (e_res_valid) begin
                check("res_resp", res_resp, e_resp);
                check("res_data", res_data, e_rdata);
            end
        end
    end

    // Publish model-derived expectations, observe, and advance one cycle.
    task automatic tick();
        e_err   = m_err;
        e_done  = CW'(m_done);
        e_resp  = m_resp;
        e_rdata = m_data;
        e_to    = e_res_valid ? m_to : 1'b0;
        if (res_valid === 1'b1 && obs_off < 0) begin
            obs_off  = cyc_idx;
            obs_resp = res_resp;
            obs_data = res_data;
            obs_to   = res_timeout;
        end
        cyc_idx++;
        @(posedge c_clk);
        #1;
    endtask

    task automatic noise();
        op_valid  = 1'($urandom);
        op_cmd    = 4'($urandom);
        op_a      = $urandom;
        op_b      = $urandom;
        res_ready = 1'($urandom);
    endtask

    task automatic set_idle_exp();
        e_op_ready  = 1'b1;
        e_res_valid = 1'b0;
        e_req_cmd   = '0;
        e_req_data  = '0;
    endtask

    // Idle cycles; optionally inject a response on the first one (spurious).
    task automatic idle(input int n, input bit inj);
        for (int i = 0; i < n; i++) begin
            set_idle_exp();
            op_valid  = 1'b0;
            res_ready = 1'($urandom);
            out_data  = $urandom;
            out_resp  = (inj && i == 0) ? 2'(1 + $urandom_range(0, 2)) : 2'd0;
            tick();
            if (inj && i == 0) m_err = 1'b1;
        end
        out_resp = '0;
    endtask

    // One full operation. k = WAIT cycle index of the response, -1 = silent responder.
    task automatic run_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input int k, input logic [1:0] resp, input logic [31:0] rd,
                          input int hold);
        int wl;
        obs_off = -1;
        cyc_idx = 0;
        set_idle_exp();
        op_valid  = 1'b1;
        op_cmd    = cmd;
        op_a      = a;
        op_b      = b;
        res_ready = 1'($urandom);
        out_resp  = '0;
        out_data  = $urandom;
        tick();
        e_op_ready = 1'b0;
        if (cmd != 4'd0) begin
            noise(); e_req_cmd = cmd;  e_req_data = a; tick();
            noise(); e_req_cmd = 4'd0; e_req_data = b; tick();
            e_req_data = '0;
            wl = (k < 0) ? TMO : k + 1;
            for (int i = 0; i < wl; i++) begin
                noise();
                out_resp = (i == k) ? resp : 2'd0;
                out_data = (i == k) ? rd : $urandom;
                tick();
            end
            if (k < 0) begin m_resp = 2'd3; m_data = '0; m_to = 1'b1; end
            else       begin m_resp = resp; m_data = rd; m_to = 1'b0; end
        end else begin
            m_resp = 2'd0; m_data = '0; m_to = 1'b0;
        end
        out_resp    = '0;
        e_res_valid = 1'b1;
        for (int h = 0; h <= hold; h++) begin
            noise();
            res_ready = (h == hold);
            tick();
        end
        m_done    = (m_done + 1) % (1 << CW);
        op_valid  = 1'b0;
        res_ready = 1'b0;
        set_idle_exp();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cmds [6];
        logic [3:0] c;
        int k;
        reset = 1'b0; op_valid = 1'b0; op_cmd = '0; op_a = '0; op_b = '0;
        out_resp = '0; out_data = '0; res_ready = 1'b0;
        #1;
        check("rst op_ready", op_ready, 1'b1);
        check("rst res_valid", res_valid, 1'b0);
        check("rst req_cmd", req_cmd, 4'd0);
        check("rst req_data", req_data, 32'd0);
        check("rst err", err_spurious, 1'b0);
        check("rst done", done_cnt, 4'd0);
        @(posedge c_clk); @(posedge c_clk); #1;
        reset = 1'b1;
        set_idle_exp();
        chk_en = 1'b1;
        idle(2, 1'b0);

        // add 5,3 answered on cycle 4
        run_op(4'd1, 32'd5, 32'd3, 1, 2'd1, 32'd8, 0);
        check("t1 latency", obs_off, 5);
        check("t1 resp", obs_resp, 2'd1);
        check("t1 data", obs_data, 32'd8);
        check("t1 done", done_cnt, 4'd1);

        // overflow response passed through
        run_op(4'd1, 32'hFFFF_FFFF, 32'd1, 1, 2'd2, 32'd0, 0);
        check("t2 resp", obs_resp, 2'd2);
        check("t2 timeout", obs_to, 1'b0);
        check("t2 err", err_spurious, 1'b0);

        // silent responder -> timeout, then a late response in IDLE
        run_op(4'd5, 32'd1, 32'd4, -1, 2'd0, 32'd0, 0);
        check("t3 latency", obs_off, 67);
        check("t3 resp", obs_resp, 2'd3);
        check("t3 data", obs_data, 32'd0);
        check("t3 timeout", obs_to, 1'b1);
        idle(1, 1'b1);
        idle(3, 1'b0);
        check("t3 err sticky", err_spurious, 1'b1);

        // result held 10 cycles, then back-to-back op
        run_op(4'd2, 32'd10, 32'd4, 2, 2'd1, 32'd6, 10);
        check("t4 latency", obs_off, 6);
        run_op(4'd6, 32'h80, 32'd3, 0, 2'd1, 32'h10, 0);
        check("t4 b2b latency", obs_off, 4);

        // response on the terminal-count cycle wins over timeout
        run_op(4'd1, 32'd7, 32'd8, TMO - 1, 2'd1, 32'd15, 0);
        check("tc latency", obs_off, 67);
        check("tc timeout", obs_to, 1'b0);
        check("tc data", obs_data, 32'd15);

        // no-op
        run_op(4'd0, 32'h1234, 32'h5678, 0, 2'd1, 32'd0, 0);
        check("t6 latency", obs_off, 1);
        check("t6 resp", obs_resp, 2'd0);

        // reset in WAIT
        set_idle_exp();
        op_valid = 1'b1; op_cmd = 4'd1; op_a = 32'd9; op_b = 32'd9; out_resp = '0;
        tick();
        e_op_ready = 1'b0;
        noise(); e_req_cmd = 4'd1; e_req_data = 32'd9; tick();
        noise(); e_req_cmd = 4'd0; e_req_data = 32'd9; tick();
        e_req_data = '0;
        for (int i = 0; i < 5; i++) begin noise(); tick(); end
        chk_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("t5 req_cmd", req_cmd, 4'd0);
        check("t5 req_data", req_data, 32'd0);
        check("t5 res_valid", res_valid, 1'b0);
        check("t5 op_ready", op_ready, 1'b1);
        op_valid = 1'b0; res_ready = 1'b0;
        @(posedge c_clk); @(posedge c_clk); #1;
        reset  = 1'b1;
        m_done = 0;
        m_err  = 1'b0;
        set_idle_exp();
        chk_en = 1'b1;
        idle(5, 1'b0);
        check("t5 done", done_cnt, 4'd0);

        // randomized ops
        cmds[0] = 4'd0; cmds[1] = 4'd1; cmds[2] = 4'd2;
        cmds[3] = 4'd5; cmds[4] = 4'd6; cmds[5] = 4'd0;
        for (int n = 0; n < 40; n++) begin
            c = cmds[$urandom_range(0, 5)];
            if (n % 6 == 5) c = 4'($urandom);
            case ($urandom_range(0, 9))
                0:       k = -1;
                1:       k = TMO - 1;
                default: k = $urandom_range(0, 7);
            endcase
            run_op(c, $urandom, $urandom, k, 2'(1 + $urandom_range(0, 2)), $urandom,
                   $urandom_range(0, 3));
            idle($urandom_range(0, 2), ($urandom_range(0, 5) == 0));
        end
        idle(2, 1'b0);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
